// File: rtl/aes_v3_pkg.sv
// Shared types, cycle constants and GF(2^8) helpers for the AES column sequencer.
package aes_v3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_MIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int SUB_CYCLES = 4;
  localparam int MIX_CYCLES = 4;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = gf_mul(a, a);
    r  = sq;
    for (int i = 0; i < 6; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_v3_2.sv
// Single-byte AES datapath: (Inv)SubBytes of byte bs, or the (Inv)MixColumns
// contribution of byte bs, rotated into place. Contains the only S-box.
module aes_sbox
  import aes_v3_pkg::*;
(
  input  logic       dec,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] pre;
  logic [7:0] inv;

  always_comb begin
    pre  = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
    inv  = gf_inv(dec ? pre : din);
    dout = dec ? inv
               : inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_v3_2
  import aes_v3_pkg::*;
(
  input  logic        valid,
  input  logic        dec,
  input  logic        mix,
  input  logic [31:0] rs1,
  input  logic [1:0]  bs,
  output logic [31:0] rd
);

  logic [7:0]  sel;
  logic [7:0]  sb;
  logic [31:0] word;
  logic [31:0] rot;

  // Operand gating keeps the S-box inputs quiet when the sequencer is idle.
  always_comb begin
    sel = '0;
    if (valid) sel = rs1[8*bs +: 8];
  end

  aes_sbox u_sbox (
    .dec  (dec),
    .din  (sel),
    .dout (sb)
  );

  always_comb begin
    if (!mix)
      word = {24'h0, sb};
    else if (!dec)
      word = {gf_mul(sel, 8'h03), sel, sel, gf_mul(sel, 8'h02)};
    else
      word = {gf_mul(sel, 8'h0b), gf_mul(sel, 8'h0d), gf_mul(sel, 8'h09), gf_mul(sel, 8'h0e)};

    case (bs)
      2'd0:    rot = word;
      2'd1:    rot = {word[23:0], word[31:24]};
      2'd2:    rot = {word[15:0], word[31:16]};
      default: rot = {word[7:0],  word[31:8]};
    endcase

    rd = valid ? rot : 32'h0;
  end

endmodule

// File: rtl/aes_v3_2_seq.sv
// Byte-serial AES column sequencer: 4 SubBytes cycles, optional 4 MixColumns
// cycles, then a held response. Optional flush port under AES_V3_2_SEQ_FLUSH_EN.
module aes_v3_2_seq
  import aes_v3_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_resetn,
`ifdef AES_V3_2_SEQ_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_dec,
  input  logic        req_mix,
  input  logic [31:0] req_col,
  input  logic [31:0] req_key,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy
);

  state_t      state;
  logic [1:0]  bs;
  logic [31:0] col;
  logic [31:0] acc;
  logic [31:0] key;
  logic        dec;
  logic        mix;
  logic [31:0] rd;
  logic        kill;

`ifdef AES_V3_2_SEQ_FLUSH_EN
  assign kill = flush && (state != ST_IDLE);
`else
  assign kill = 1'b0;
`endif

  aes_v3_2 u_dp (
    .valid (state == ST_SUB || state == ST_MIX),
    .dec   (dec),
    .mix   (state == ST_MIX),
    .rs1   (col),
    .bs    (bs),
    .rd    (rd)
  );

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_data  = rsp_valid ? acc : 32'h0;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state     <= ST_IDLE;
      bs        <= '0;
      col       <= '0;
      acc       <= '0;
      key       <= '0;
      dec       <= 1'b0;
      mix       <= 1'b0;
      rsp_valid <= 1'b0;
    end else if (kill) begin
      state     <= ST_IDLE;
      bs        <= '0;
      acc       <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            col   <= req_col;
            key   <= req_key;
            dec   <= req_dec;
            mix   <= req_mix;
            acc   <= '0;
            bs    <= '0;
            state <= ST_SUB;
          end
        end
        ST_SUB: begin
          bs <= bs + 2'd1;
          if (bs == 2'(SUB_CYCLES - 1)) begin
            // Substituted column becomes the MixColumns operand.
            if (mix) begin
              col   <= acc ^ rd;
              acc   <= '0;
              state <= ST_MIX;
            end else begin
              acc   <= acc ^ rd ^ key;
              state <= ST_DONE;
            end
          end else begin
            acc <= acc ^ rd;
          end
        end
        ST_MIX: begin
          bs <= bs + 2'd1;
          if (bs == 2'(MIX_CYCLES - 1)) begin
            acc   <= acc ^ rd ^ key;
            state <= ST_DONE;
          end else begin
            acc <= acc ^ rd;
          end
        end
        ST_DONE: begin
          // Response is raised one cycle after entering DONE, then held.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_v3_2_seq.sv
// Directed, table-driven bench for aes_v3_2_seq; flush sequence is built only
// when AES_V3_2_SEQ_FLUSH_EN is defined.
module tb_aes_v3_2_seq;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_dec = 1'b0;
  logic        req_mix = 1'b0;
  logic [31:0] req_col = '0;
  logic [31:0] req_key = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        busy;
`ifdef AES_V3_2_SEQ_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  aes_v3_2_seq dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
`ifdef AES_V3_2_SEQ_FLUSH_EN
    .flush     (flush),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dec   (req_dec),
    .req_mix   (req_mix),
    .req_col   (req_col),
    .req_key   (req_key),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  typedef struct {
    logic        dec;
    logic        mix;
    logic [31:0] col;
    logic [31:0] key;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one request; returns cycles from acceptance edge to rsp_valid and the data.
  task automatic issue(input logic dec, input logic mix, input logic [31:0] col,
                       input logic [31:0] key, output int lat, output logic [31:0] data);
    @(negedge g_clk);
    req_dec   = dec;
    req_mix   = mix;
    req_col   = col;
    req_key   = key;
    req_valid = 1'b1;
    @(posedge g_clk);
    #1;
    req_valid = 1'b0;
    check("busy_after_accept", {31'h0, busy}, 32'h1);
    check("ready_low_in_flight", {31'h0, req_ready}, 32'h0);
    lat = 0;
    data = '0;
    while (1) begin
      @(posedge g_clk);
      #1;
      lat++;
      if (rsp_valid) begin
        data = rsp_data;
        break;
      end
      if (lat > 40) begin
        $display("FAIL rsp_timeout actual=%0d required=<=40", lat);
        errors++;
        checks++;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] data;
    logic [31:0] held;
    logic        seen;

    vecs[0] = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h63636363, 5};
    vecs[1] = '{1'b0, 1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h9C9C9C9C, 9};
    vecs[2] = '{1'b1, 1'b1, 32'h63636363, 32'h00000000, 32'h00000000, 9};
    vecs[3] = '{1'b1, 1'b0, 32'hEDEDEDED, 32'h00000000, 32'h53535353, 5};
    vecs[4] = '{1'b0, 1'b0, 32'h53010010, 32'h0000000F, 32'hED7C63C5, 5};
    vecs[5] = '{1'b1, 1'b0, 32'hED7C63CA, 32'h00000000, 32'h53010010, 5};
    vecs[6] = '{1'b0, 1'b1, 32'h00000001, 32'h12345678, 32'h50482A25, 9};
    vecs[7] = '{1'b1, 1'b1, 32'h0000007C, 32'h00000000, 32'h09F8AF0D, 9};

    // Reset state
    #12;
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(posedge g_clk);
    #1;
    check("rel_req_ready", {31'h0, req_ready}, 32'h1);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      check($sformatf("v%0d_ready", i), {31'h0, req_ready}, 32'h1);
      issue(vecs[i].dec, vecs[i].mix, vecs[i].col, vecs[i].key, lat, data);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_data", i), data, vecs[i].exp);
      @(posedge g_clk);
      #1;
      check($sformatf("v%0d_valid_drop", i), {31'h0, rsp_valid}, 32'h0);
      check($sformatf("v%0d_data_zero", i), rsp_data, 32'h0);
      check($sformatf("v%0d_ready_back", i), {31'h0, req_ready}, 32'h1);
    end

    // Backpressure: response held while rsp_ready low; new request ignored
    rsp_ready = 1'b0;
    issue(1'b0, 1'b0, 32'h00000000, 32'h00000000, lat, held);
    check("bp_data", held, 32'h63636363);
    @(negedge g_clk);
    req_valid = 1'b1;
    req_col   = 32'hDEADBEEF;
    for (int c = 0; c < 5; c++) begin
      @(posedge g_clk);
      #1;
      check("bp_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp_data_stable", rsp_data, held);
      check("bp_ready_low", {31'h0, req_ready}, 32'h0);
    end
    @(negedge g_clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge g_clk);
    #1;
    check("bp_handoff_valid", {31'h0, rsp_valid}, 32'h0);
    check("bp_idle", {31'h0, busy}, 32'h0);

    // Reset asserted during MIX
    @(negedge g_clk);
    req_dec = 1'b0; req_mix = 1'b1; req_col = 32'h00000000; req_key = 32'hFFFFFFFF;
    req_valid = 1'b1;
    @(posedge g_clk);
    #1;
    req_valid = 1'b0;
    repeat (6) @(posedge g_clk);
    #2;
    check("mid_busy_before_rst", {31'h0, busy}, 32'h1);
    g_resetn = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
    check("mid_rst_data", rsp_data, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge g_clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_no_spurious", {31'h0, seen}, 32'h0);
    check("mid_ready", {31'h0, req_ready}, 32'h1);

`ifdef AES_V3_2_SEQ_FLUSH_EN
    // Flush during SUB, then a clean request
    @(negedge g_clk);
    req_dec = 1'b0; req_mix = 1'b1; req_col = 32'h00000000; req_key = 32'hFFFFFFFF;
    req_valid = 1'b1;
    @(posedge g_clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge g_clk);
    #1;
    flush = 1'b1;
    @(posedge g_clk);
    #1;
    flush = 1'b0;
    check("flush_idle", {31'h0, busy}, 32'h0);
    check("flush_ready", {31'h0, req_ready}, 32'h1);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge g_clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("flush_no_rsp", {31'h0, seen}, 32'h0);
    issue(1'b0, 1'b1, 32'h00000000, 32'hFFFFFFFF, lat, data);
    check("flush_next_lat", lat, 9);
    check("flush_next_data", data, 32'h9C9C9C9C);
    @(posedge g_clk);
    #1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
